// File: rtl/ecr_pkg.sv
// Shared definitions for the ECR cipher link: field widths, the eight cipher codes, rx state encoding.
// Latency: none (constants only). Backpressure: not applicable.
// Used by both the encoder and decrip_rx/decrip_lut so the code table lives in one place.
package ecr_pkg;

    localparam int ECR_W  = 5;
    localparam int DATA_W = 3;

    localparam logic [ECR_W-1:0] ECR_CODE_0 = 5'd6;
    localparam logic [ECR_W-1:0] ECR_CODE_1 = 5'd5;
    localparam logic [ECR_W-1:0] ECR_CODE_2 = 5'd10;
    localparam logic [ECR_W-1:0] ECR_CODE_3 = 5'd16;
    localparam logic [ECR_W-1:0] ECR_CODE_4 = 5'd1;
    localparam logic [ECR_W-1:0] ECR_CODE_5 = 5'd8;
    localparam logic [ECR_W-1:0] ECR_CODE_6 = 5'd11;
    localparam logic [ECR_W-1:0] ECR_CODE_7 = 5'd20;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        FULL   = 2'd1,
        LOCKED = 2'd2
    } state_t;

endpackage

// File: rtl/decrip_lut.sv
// Inverse cipher table: 5-bit code -> {hit, 3-bit data}; codes outside the table give hit=0, data=0.
// Latency: combinational. Backpressure: none.
module decrip_lut
    import ecr_pkg::*;
(
    input  logic [ECR_W-1:0]  code,
    output logic              hit,
    output logic [DATA_W-1:0] data
);

    always_comb begin
        hit  = 1'b1;
        data = '0;
        unique case (code)
            ECR_CODE_0: data = 3'd0;
            ECR_CODE_1: data = 3'd1;
            ECR_CODE_2: data = 3'd2;
            ECR_CODE_3: data = 3'd3;
            ECR_CODE_4: data = 3'd4;
            ECR_CODE_5: data = 3'd5;
            ECR_CODE_6: data = 3'd6;
            ECR_CODE_7: data = 3'd7;
            default:    hit  = 1'b0;
        endcase
    end

endmodule

// File: rtl/decrip_rx.sv
// ECR receive decoder with one-entry output register, bad-code flagging and lock after ERR_LIMIT bad codes in a row.
// Latency: 1 cycle accept->Dv. Backpressure: ECRr follows Dr while a beat is held, 0 when LOCKED; no bubble on replace.
// Optional saturating bad-code counter on ERRCNT when DECRIP_ERRCNT_EN is defined, else ERRCNT is tied to 0.
module decrip_rx
    import ecr_pkg::*;
#(
    parameter int ERR_LIMIT = 3,
    parameter int ERRCNT_W  = 8
)(
    input  logic                CLK,
    input  logic                RST,
    input  logic [ECR_W-1:0]    ECRi,
    input  logic                ECRv,
    output logic                ECRr,
    output logic [DATA_W-1:0]   Dout,
    output logic                Dv,
    input  logic                Dr,
    output logic                Derr,
    output logic                LOCK,
    input  logic                CLR,
    output logic [ERRCNT_W-1:0] ERRCNT
);

    state_t            state;
    logic [3:0]        err_run;
    logic              hit;
    logic [DATA_W-1:0] lut_dat;
    logic              accept;
    logic              consume;
    logic [4:0]        run_inc;
    logic              lock_hit;

    decrip_lut u_lut (
        .code (ECRi),
        .hit  (hit),
        .data (lut_dat)
    );

    always_comb begin
        ECRr = 1'b0;
        unique case (state)
            EMPTY:   ECRr = 1'b1;
            FULL:    ECRr = Dr;
            default: ECRr = 1'b0;
        endcase
    end

    assign accept   = ECRv && ECRr;
    assign consume  = Dv && Dr;
    assign run_inc  = {1'b0, err_run} + 5'd1;
    assign lock_hit = !hit && (run_inc >= 5'(ERR_LIMIT));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= EMPTY;
            err_run <= '0;
            Dout    <= '0;
            Dv      <= 1'b0;
            Derr    <= 1'b0;
            LOCK    <= 1'b0;
        end else begin
            unique case (state)
                EMPTY, FULL: begin
                    if (accept) begin
                        Dout <= hit ? lut_dat : '0;
                        Derr <= !hit;
                        Dv   <= 1'b1;
                        // CLR beats a simultaneous bad code: the run restarts and no lock is taken
                        if (CLR || hit) begin
                            err_run <= '0;
                            state   <= FULL;
                        end else if (lock_hit) begin
                            err_run <= 4'(ERR_LIMIT);
                            LOCK    <= 1'b1;
                            state   <= LOCKED;
                        end else begin
                            err_run <= run_inc[3:0];
                            state   <= FULL;
                        end
                    end else begin
                        if (CLR)
                            err_run <= '0;
                        if (consume) begin
                            Dv    <= 1'b0;
                            state <= EMPTY;
                        end
                    end
                end
                default: begin
                    if (consume)
                        Dv <= 1'b0;
                    if (CLR) begin
                        LOCK    <= 1'b0;
                        err_run <= '0;
                        state   <= (Dv && !consume) ? FULL : EMPTY;
                    end
                end
            endcase
        end
    end

`ifdef DECRIP_ERRCNT_EN
    always_ff @(posedge CLK) begin
        if (RST)
            ERRCNT <= '0;
        else if (accept && !hit && (ERRCNT != '1))
            ERRCNT <= ERRCNT + ERRCNT_W'(1);
    end
`else
    assign ERRCNT = '0;
`endif

endmodule

// File: tb/tb_decrip_rx.sv
// Directed self-checking bench for decrip_rx: decode table, backpressure, lock/clear, reset, error counter.
module tb_decrip_rx;
    import ecr_pkg::*;

    logic             CLK = 1'b0;
    logic             RST;
    logic [ECR_W-1:0] ECRi;
    logic             ECRv;
    logic             ECRr;
    logic [DATA_W-1:0] Dout;
    logic             Dv;
    logic             Dr;
    logic             Derr;
    logic             LOCK;
    logic             CLR;
    logic [7:0]       ERRCNT;

    int total = 0;
    int bad   = 0;

    decrip_rx #(.ERR_LIMIT(3), .ERRCNT_W(8)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .ECRi   (ECRi),
        .ECRv   (ECRv),
        .ECRr   (ECRr),
        .Dout   (Dout),
        .Dv     (Dv),
        .Dr     (Dr),
        .Derr   (Derr),
        .LOCK   (LOCK),
        .CLR    (CLR),
        .ERRCNT (ERRCNT)
    );

    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        RST = 1'b1; ECRi = '0; ECRv = 1'b0; Dr = 1'b0; CLR = 1'b0;
        tick; tick;
        RST = 1'b0;
        #1;
        total++; if (Dv !== 1'b0) begin bad++; $display("FAIL reset_dv got=%0d want=0", Dv); end
        total++; if (Dout !== 3'd0) begin bad++; $display("FAIL reset_dout got=%0d want=0", Dout); end
        total++; if (Derr !== 1'b0) begin bad++; $display("FAIL reset_derr got=%0d want=0", Derr); end
        total++; if (LOCK !== 1'b0) begin bad++; $display("FAIL reset_lock got=%0d want=0", LOCK); end
        total++; if (ERRCNT !== 8'd0) begin bad++; $display("FAIL reset_errcnt got=%0d want=0", ERRCNT); end
        total++; if (ECRr !== 1'b1) begin bad++; $display("FAIL reset_ecrr got=%0d want=1", ECRr); end
    endtask

    task automatic test_decode;
        logic [4:0] codes [8];
        codes = '{5'd6, 5'd5, 5'd10, 5'd16, 5'd1, 5'd8, 5'd11, 5'd20};
        Dr = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ECRi = codes[i]; ECRv = 1'b1;
            #1;
            total++; if (ECRr !== 1'b1) begin bad++; $display("FAIL decode_ecrr[%0d] got=%0d want=1", i, ECRr); end
            tick;
            total++; if (Dv !== 1'b1) begin bad++; $display("FAIL decode_dv[%0d] got=%0d want=1", i, Dv); end
            total++; if (Dout !== 3'(i)) begin bad++; $display("FAIL decode_dout code=%0d got=%0d want=%0d", codes[i], Dout, i); end
            total++; if (Derr !== 1'b0) begin bad++; $display("FAIL decode_derr[%0d] got=%0d want=0", i, Derr); end
        end
        ECRv = 1'b0;
        tick;
        total++; if (Dv !== 1'b0) begin bad++; $display("FAIL decode_drain got=%0d want=0", Dv); end
    endtask

    task automatic test_backpressure;
        Dr = 1'b1; ECRi = 5'd16; ECRv = 1'b1;
        tick;
        Dr = 1'b0; ECRi = 5'd1;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++; if (ECRr !== 1'b0) begin bad++; $display("FAIL bp_ecrr[%0d] got=%0d want=0", i, ECRr); end
            total++; if (Dv !== 1'b1 || Dout !== 3'd3) begin bad++; $display("FAIL bp_hold[%0d] got dv=%0d dout=%0d want dv=1 dout=3", i, Dv, Dout); end
            tick;
        end
        Dr = 1'b1;
        #1;
        total++; if (ECRr !== 1'b1) begin bad++; $display("FAIL bp_release_ecrr got=%0d want=1", ECRr); end
        tick;
        total++; if (Dv !== 1'b1 || Dout !== 3'd4) begin bad++; $display("FAIL bp_no_bubble got dv=%0d dout=%0d want dv=1 dout=4", Dv, Dout); end
        ECRv = 1'b0;
        tick;
        total++; if (Dv !== 1'b0) begin bad++; $display("FAIL bp_drain got=%0d want=0", Dv); end
    endtask

    task automatic test_lock;
        logic [4:0] codes [6];
        logic       errs  [6];
        codes = '{5'd0, 5'd2, 5'd6, 5'd3, 5'd4, 5'd7};
        errs  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        Dr = 1'b1;
        for (int i = 0; i < 6; i++) begin
            ECRi = codes[i]; ECRv = 1'b1;
            tick;
            total++; if (Derr !== errs[i] || Dv !== 1'b1) begin bad++; $display("FAIL lock_derr[%0d] got derr=%0d dv=%0d want derr=%0d dv=1", i, Derr, Dv, errs[i]); end
            total++; if (Dout !== 3'd0) begin bad++; $display("FAIL lock_dout[%0d] got=%0d want=0", i, Dout); end
            total++; if (LOCK !== (i == 5)) begin bad++; $display("FAIL lock_flag[%0d] got=%0d want=%0d", i, LOCK, (i == 5)); end
        end
        ECRv = 1'b1; ECRi = 5'd20; Dr = 1'b0;
        #1;
        total++; if (ECRr !== 1'b0) begin bad++; $display("FAIL locked_ecrr got=%0d want=0", ECRr); end
        tick;
        total++; if (Dv !== 1'b1 || Derr !== 1'b1) begin bad++; $display("FAIL locked_hold got dv=%0d derr=%0d want 1 1", Dv, Derr); end
        Dr = 1'b1;
        #1;
        total++; if (ECRr !== 1'b0) begin bad++; $display("FAIL locked_ecrr_dr got=%0d want=0", ECRr); end
        tick;
        total++; if (Dv !== 1'b0 || LOCK !== 1'b1) begin bad++; $display("FAIL locked_consume got dv=%0d lock=%0d want dv=0 lock=1", Dv, LOCK); end
        ECRv = 1'b0; CLR = 1'b1;
        tick;
        CLR = 1'b0;
        #1;
        total++; if (LOCK !== 1'b0 || ECRr !== 1'b1) begin bad++; $display("FAIL clr_unlock got lock=%0d ecrr=%0d want lock=0 ecrr=1", LOCK, ECRr); end
        ECRi = 5'd20; ECRv = 1'b1;
        tick;
        ECRv = 1'b0;
        total++; if (Dv !== 1'b1 || Dout !== 3'd7 || Derr !== 1'b0) begin bad++; $display("FAIL after_clr got dv=%0d dout=%0d derr=%0d want 1 7 0", Dv, Dout, Derr); end
        tick;
    endtask

    task automatic test_clr_wins;
        Dr = 1'b1; ECRv = 1'b1; ECRi = 5'd0;
        tick; tick;
        CLR = 1'b1;
        tick;
        CLR = 1'b0;
        total++; if (LOCK !== 1'b0 || Derr !== 1'b1) begin bad++; $display("FAIL clr_wins got lock=%0d derr=%0d want lock=0 derr=1", LOCK, Derr); end
        tick; tick;
        total++; if (LOCK !== 1'b0) begin bad++; $display("FAIL clr_run_reset got lock=%0d want=0", LOCK); end
        tick;
        total++; if (LOCK !== 1'b1) begin bad++; $display("FAIL clr_relock got lock=%0d want=1", LOCK); end
        ECRv = 1'b0; CLR = 1'b1;
        tick;
        CLR = 1'b0;
        #1;
        total++; if (LOCK !== 1'b0 || ECRr !== 1'b1) begin bad++; $display("FAIL clr_exit got lock=%0d ecrr=%0d want 0 1", LOCK, ECRr); end
    endtask

    task automatic test_reset_mid;
        Dr = 1'b1; ECRv = 1'b1; ECRi = 5'd16;
        tick;
        Dr = 1'b0; ECRv = 1'b0;
        tick;
        RST = 1'b1;
        tick;
        RST = 1'b0;
        total++; if (Dv !== 1'b0 || Dout !== 3'd0 || LOCK !== 1'b0) begin bad++; $display("FAIL rst_full got dv=%0d dout=%0d lock=%0d want 0 0 0", Dv, Dout, LOCK); end
        Dr = 1'b1; ECRv = 1'b1; ECRi = 5'd31;
        tick; tick; tick;
        ECRv = 1'b0; Dr = 1'b0;
        total++; if (LOCK !== 1'b1) begin bad++; $display("FAIL rst_prelock got lock=%0d want=1", LOCK); end
        RST = 1'b1;
        tick;
        RST = 1'b0;
        #1;
        total++; if (LOCK !== 1'b0 || Dv !== 1'b0 || Derr !== 1'b0 || ECRr !== 1'b1) begin bad++; $display("FAIL rst_locked got lock=%0d dv=%0d derr=%0d ecrr=%0d want 0 0 0 1", LOCK, Dv, Derr, ECRr); end
    endtask

    task automatic test_errcnt;
        logic [7:0] want;
`ifdef DECRIP_ERRCNT_EN
        want = 8'd255;
`else
        want = 8'd0;
`endif
        Dr = 1'b1; ECRv = 1'b1; ECRi = 5'd0;
        for (int i = 0; i < 300; i++) begin
            CLR = (i % 2 == 0);
            tick;
        end
        CLR = 1'b0; ECRv = 1'b0;
        tick;
        total++; if (LOCK !== 1'b0) begin bad++; $display("FAIL errcnt_nolock got=%0d want=0", LOCK); end
        total++; if (ERRCNT !== want) begin bad++; $display("FAIL errcnt_sat got=%0d want=%0d", ERRCNT, want); end
        CLR = 1'b1;
        tick;
        CLR = 1'b0;
        tick;
        total++; if (ERRCNT !== want) begin bad++; $display("FAIL errcnt_clr got=%0d want=%0d", ERRCNT, want); end
        RST = 1'b1;
        tick;
        RST = 1'b0;
        total++; if (ERRCNT !== 8'd0) begin bad++; $display("FAIL errcnt_rst got=%0d want=0", ERRCNT); end
    endtask

    initial begin
        test_reset;
        test_decode;
        test_backpressure;
        test_lock;
        test_clr_wins;
        test_reset_mid;
        test_errcnt;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decrip_rx.md
Name: decrip_rx

Overview:
Receive-side inverse of the team's 3-bit → 5-bit encryption table. It accepts 5-bit cipher codes over a valid/ready handshake, decodes them back to 3-bit data and delivers them through a one-entry registered output stage with backpressure. Codes outside the table are flagged. A run of consecutive bad codes locks the block until software issues a clear. It sits at the consumer end of the encrypted link, directly downstream of the transport carrying ECR codes.

Parameters:
ERR_LIMIT, 3, number of consecutive invalid codes that forces LOCKED (legal range 1..15).
ERRCNT_W, 8, width of the optional saturating total-error counter.

Ports:
CLK  input  1  system clock, all logic on rising edge.
RST  input  1  synchronous reset, active-high; one clock, overrides all other inputs.
ECRi  input  5  incoming cipher code.
ECRv  input  1  ECRi valid.
ECRr  output  1  ready to accept ECRi.
Dout  output  3  decoded data.
Dv  output  1  Dout/Derr valid.
Dr  input  1  downstream ready.
Derr  output  1  current beat carried an invalid code.
LOCK  output  1  block locked after ERR_LIMIT consecutive errors.
CLR  input  1  clears lock and error run.
ERRCNT  output  ERRCNT_W  total invalid codes (optional feature).

Behaviour:
- Reset is synchronous and active-high.
- Reset values: Dout=0, Dv=0, Derr=0, LOCK=0, ERRCNT=0, err_run=0, state=EMPTY.
- Code table (code→data): 6→0, 5→1, 10→2, 16→3, 1→4, 8→5, 11→6, 20→7. All other 24 codes are invalid.
- FSM states: EMPTY (no beat held), FULL (beat held, Dv=1), LOCKED (LOCK=1).
- ECRr is combinational: 1 in EMPTY; equals Dr in FULL; 0 in LOCKED.
- Accept occurs when ECRv && ECRr. Latency is 1 cycle: the decoded beat appears on Dout/Dv on the cycle after accept.
- Valid code on accept: Dout=decoded value, Derr=0, Dv=1, err_run cleared to 0.
- Invalid code on accept: Dout=0, Derr=1, Dv=1, err_run+1.
  - If err_run+1 reaches ERR_LIMIT, go to LOCKED with LOCK=1.
  - Otherwise go to FULL.
- Consume occurs when Dv && Dr.
- FULL:
  - Consume without accept → EMPTY, Dv=0.
  - Consume and accept in the same cycle → the new beat replaces the old one; stay FULL (or go to LOCKED by the rule above). There is no bubble.
  - No consume → hold Dout/Derr/Dv stable; ECRi is ignored.
- LOCKED:
  - No new accepts.
  - The error beat that caused the lock is still presented and drops on consume (Dv=0).
  - LOCK stays at 1 until CLR.
- CLR:
  - In LOCKED: LOCK=0, err_run=0. Next state is FULL if Dv is still 1, else EMPTY. Takes effect the next cycle.
  - Outside LOCKED: clears err_run only.
  - CLR in the same cycle as an invalid accept: CLR wins and err_run ends at 0.
- err_run saturates at ERR_LIMIT. Dout and Derr are don't-care when Dv=0 but are held at their last value.
- RST asserted mid-operation (including in LOCKED or with Dv=1): the held beat is discarded without handshake and all reset values apply the next cycle.

Optional Feature:
- Macro: DECRIP_ERRCNT_EN.
- Defined: ERRCNT increments on every invalid accept, saturates at all-ones, and is cleared only by RST (not by CLR).
- Undefined: the counter logic is omitted and ERRCNT is tied to 0. The port list is identical in both builds.

Decomposition:
- Shared package ecr_pkg holds:
  - ECR_W=5 and DATA_W=3.
  - The eight code constants ECR_CODE_0..7, also used by the encoder.
  - The state enum (EMPTY, FULL, LOCKED).
- One natural sub-module: decrip_lut, purely combinational. Maps code → {hit, data[2:0]} from the package constants. All sequential logic stays in decrip_rx.

Test Plan:
- Reset, then send codes 6,5,10,16,1,8,11,20 with Dr=1 throughout → Dout 0..7 one cycle after each accept; Derr=0; ECRr stays 1.
- Send code 16 with Dr=0 for 4 cycles → Dv=1 and Dout=3 held stable; ECRr=0. Then raise Dr while ECRv=1 with code 1 → next cycle Dout=4, with no bubble.
- ERR_LIMIT=3; send 0, 2, 6, 3, 4, 7 → Derr pattern 1,1,0,1,1,1. LOCK rises after the beat carrying code 7; ECRr=0 afterwards.
- In LOCKED, consume the error beat and then pulse CLR → LOCK=0 and state EMPTY. Code 20 is then accepted → Dout=7.
- Assert RST while FULL with Dv=1 and Dr=0 → next cycle Dv=0, Dout=0, LOCK=0.
- DECRIP_ERRCNT_EN defined with ERRCNT_W=8; send 300 invalid codes interleaved with CLR pulses → ERRCNT=255, and CLR does not clear it.
